seven_seg_updown_mux: RTL
=========================

# seven_seg_updown_mux

Multi-digit hexadecimal up/down counter that drives a time-multiplexed common-anode seven-segment display. It advances one step per programmable period and supports four modes: up-wrap, down-wrap, bounce and hold. It also has synchronous load and direction indication on the decimal point. It sits directly on the board display pins, next to the single-digit counter display blocks, and generalises them to N digits, arbitrary step rate and arbitrary terminal value.

## Interface
- DIGITS, 4: number of display digits; counter width W = 4*DIGITS.
- STEP_DIV, 100000000: clock cycles per count step (1 s at 100 MHz); must be ≥ 2.
- SCAN_DIV, 100000: clock cycles each digit stays selected (1 ms at 100 MHz); must be ≥ 2.
- MAX_VAL, 2^W-1: terminal count, ≤ 2^W-1; counter range is 0..MAX_VAL.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  step enable; when low, step prescaler holds its count and no steps occur.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
- load  in  1  one-cycle pulse; loads load_val.
- load_val  in  W  value to load.
- seg  out  7  {A,B,C,D,E,F,G}, active-high, registered.
- an  out  DIGITS  digit enables, active-low, one-hot-low, registered.
- dp  out  1  decimal point, active-low, registered.
- value  out  W  current count, registered.
- dir  out  1  0 = counting up, 1 = counting down, registered.

## Operation
- Step prescaler: step_cnt counts 0..STEP_DIV-1 while en=1. The cycle it equals STEP_DIV-1 is a step tick, and step_cnt returns to 0 on the next edge.
- On a step tick, by mode:
  - up-wrap: value+1; MAX_VAL → 0. dir forced 0.
  - down-wrap: value-1; 0 → MAX_VAL. dir forced 1.
  - bounce, dir=0: value+1. If value==MAX_VAL, dir←1 and value←MAX_VAL-1 in the same edge.
  - bounce, dir=1: value-1. If value==0, dir←0 and value←1 in the same edge.
  - Each endpoint is therefore displayed for exactly one step period.
  - hold: value and dir unchanged.
- Bounce with MAX_VAL==0: value stays 0 and dir toggles each tick.
- Mode changes take effect at the next tick. Entering bounce keeps the current dir.
- Load has priority: load=1 sets value←min(load_val, MAX_VAL) and step_cnt←0. dir is unchanged. A tick in the same cycle is discarded.
- Scan prescaler: scan_cnt counts 0..SCAN_DIV-1 unconditionally (ignores en). At terminal count, digit index d advances 0→1→…→DIGITS-1→0.
- Display outputs, registered from the current d and value:
  - an: bit d low, all other bits high.
  - seg: hex glyph of value[4d+3:4d]:
    - 0=1111110, 1=0110000, 2=1101101, 3=1111001
    - 4=0110011, 5=1011011, 6=1011111, 7=1110000
    - 8=1111111, 9=1110011, A=1110111, b=0011111
    - C=1001110, d=0111101, E=1001111, F=1000111
  - dp: low only when d==0 and dir==1, else high.
- Arithmetic is W-bit unsigned. Wrap is explicit against MAX_VAL, not modulo 2^W.

## Timing
- Reset values (rst sampled high at an edge; holds while rst stays high):
  - value=0, dir=0, step_cnt=0, scan_cnt=0, d=0.
  - seg=0000000, an=all ones (blank), dp=1.
- First edge after rst deasserts: an bit0 low, seg shows glyph of 0.
- value/dir update on the edge at the end of the tick cycle. seg/an/dp reflect new state one edge later (1-cycle display latency).
- First step after reset or load occurs STEP_DIV cycles after the deassert/load edge.
- Digit d stays selected for exactly SCAN_DIV cycles. A full refresh takes DIGITS*SCAN_DIV cycles.
- rst mid-count overrides everything, including load, on the same edge.
- en low freezes step_cnt. Re-asserting en resumes from the frozen count; no phase loss.

## Test plan
- DIGITS=2, STEP_DIV=4, SCAN_DIV=3, MAX_VAL=5, mode=00, en=1 from reset:
  - value sequence 0,1,2,3,4,5,0 with changes every 4 cycles.
  - an alternates 10/01 every 3 cycles.
  - seg=1111110 when digit 1 is selected.
- Same params, mode=10:
  - value 0,1,2,3,4,5,4,3,2,1,0,1.
  - dir rises on the 5→4 edge and falls on the 0→1 edge.
  - dp low only while an=10 and dir=1.
- mode=01 from reset: value 0→5→4; dir=1 after the first tick.
- load with load_val=8'h3C (MAX_VAL=5) on the same cycle as a tick:
  - value=5, step_cnt=0, tick discarded.
  - Next step occurs exactly 4 cycles later.
- DIGITS=4, MAX_VAL=16'hFFFF, load 16'hA1b7:
  - Over one scan cycle, seg shows 1110000 (digit0), 0011111, 0110000, 1110111 (digit3).
- en low for 10 cycles mid-period, then mode=11: no step during either; rst asserted mid-run gives all reset values on the next edge.

Source files
------------

// File: rtl/seven_seg_updown_mux_if.sv
// seven_seg_updown_mux_if: control inputs and display outputs of the
// N-digit up/down counter display, with master (driver) and slave (DUT) views.
interface seven_seg_updown_mux_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [1:0]            mode;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  dp;
  logic [4*DIGITS-1:0]   value;
  logic                  dir;

  modport master (
    output en, mode, load, load_val,
    input  seg, an, dp, value, dir
  );

  modport slave (
    input  en, mode, load, load_val,
    output seg, an, dp, value, dir
  );
endinterface

// File: rtl/seven_seg_updown_mux.sv
// seven_seg_updown_mux: N-digit hex up/down/bounce/hold counter driving a
// multiplexed common-anode 7-seg display.
// Ports: clk, rst (sync, active-high); bus.slave carries en, mode, load,
// load_val in and seg, an (active-low), dp (active-low), value, dir out.
module seven_seg_updown_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned STEP_DIV = 100000000,
  parameter int unsigned SCAN_DIV = 100000,
  parameter logic [4*DIGITS-1:0] MAX_VAL = {4*DIGITS{1'b1}}
) (
  input logic clk,
  input logic rst,
  seven_seg_updown_mux_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int SW = $clog2(STEP_DIV);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SCAN_ONE  = CW'(1);
  localparam logic [DW-1:0] D_LAST    = DW'(DIGITS - 1);
  localparam logic [DW-1:0] D_ONE     = DW'(1);
  localparam logic [W-1:0]  V_ONE     = W'(1);
  localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DN   = 2'b01,
    M_BNC  = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(bus.mode);

  logic [W-1:0]      val_q, val_d;
  logic              dir_q, dir_d;
  logic [SW-1:0]     step_q, step_d;
  logic [CW-1:0]     scan_q, scan_d;
  logic [DW-1:0]     d_q, d_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d;
  logic              tick;
  logic              scan_end;
  logic [3:0]        nib;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1110011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  assign tick     = bus.en && (step_q == STEP_LAST);
  assign scan_end = (scan_q == SCAN_LAST);

  always_comb begin
    step_d = step_q;
    if (bus.load) begin
      step_d = '0;
    end else if (bus.en) begin
      step_d = tick ? '0 : step_q + STEP_ONE;
    end
  end

  // Load wins over a coincident tick; bounce turns around at the endpoint
  // in the same edge so each endpoint is shown for exactly one period.
  always_comb begin
    val_d = val_q;
    dir_d = dir_q;
    if (bus.load) begin
      val_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (tick) begin
      unique case (mode_s)
        M_UP: begin
          val_d = (val_q == MAX_VAL) ? '0 : val_q + V_ONE;
          dir_d = 1'b0;
        end
        M_DN: begin
          val_d = (val_q == '0) ? MAX_VAL : val_q - V_ONE;
          dir_d = 1'b1;
        end
        M_BNC: begin
          if (!dir_q) begin
            if (val_q == MAX_VAL) begin
              dir_d = 1'b1;
              val_d = (MAX_VAL == '0) ? '0 : MAX_VAL - V_ONE;
            end else begin
              val_d = val_q + V_ONE;
            end
          end else begin
            if (val_q == '0) begin
              dir_d = 1'b0;
              val_d = (MAX_VAL == '0) ? '0 : V_ONE;
            end else begin
              val_d = val_q - V_ONE;
            end
          end
        end
        M_HOLD: begin
          val_d = val_q;
        end
      endcase
    end
  end

  always_comb begin
    scan_d = scan_end ? '0 : scan_q + SCAN_ONE;
    d_d    = d_q;
    if (scan_end) begin
      d_d = (d_q == D_LAST) ? '0 : d_q + D_ONE;
    end
  end

  always_comb begin
    nib  = val_q[{d_q, 2'b00} +: 4];
    seg_d = glyph(nib);
    an_d  = ~(AN_ONE << d_q);
    dp_d  = ~((d_q == '0) && dir_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= '0;
      scan_q <= '0;
      d_q    <= '0;
      seg_q  <= '0;
      an_q   <= '1;
      dp_q   <= 1'b1;
    end else begin
      val_q  <= val_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      scan_q <= scan_d;
      d_q    <= d_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.value = val_q;
  assign bus.dir   = dir_q;
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.dp    = dp_q;
endmodule
